// File: rtl/fifo_word_packer.sv
// Read-side FIFO drain that packs PACK bytes into one little-endian word on a valid/ready master.
// A partial word is flushed after TIMEOUT idle cycles; TIMEOUT=0 disables the flush.
module fifo_word_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                         rd_clk,
   input  logic                         rst,
   input  logic                         fifo_empty,
   output logic                         fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]        fifo_rdata,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH*PACK-1:0]   m_data,
   output logic [PACK-1:0]              m_keep
);

   localparam int CW = $clog2(PACK + 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW:0]   PACK_C   = (CW + 1)'(PACK);
   localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);
   localparam bit            FLUSH_EN = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                            state_reg, state_next;
   logic [CW-1:0]                     count_reg, count_next;
   logic                              in_flight_reg, in_flight_next;
   logic [TW-1:0]                     timer_reg, timer_next;
   logic [PACK-1:0][DATA_WIDTH-1:0]   acc_reg, acc_next, acc_land, acc_masked;
   logic [PACK-1:0]                   keep_partial;
   logic                              m_valid_reg, m_valid_next;
   logic [DATA_WIDTH*PACK-1:0]        m_data_reg, m_data_next;
   logic [PACK-1:0]                   m_keep_reg, m_keep_next;

   logic [CW:0] count_eff;
   logic        out_free;
   logic        pop;
   logic        word_done;
   logic        flush;

   // count_eff includes the byte landing this cycle, so a full word can leave the same cycle it completes
   assign count_eff = {1'b0, count_reg} + {{CW{1'b0}}, in_flight_reg};
   assign out_free  = !m_valid_reg || m_ready;
   assign pop       = !rst && !fifo_empty && (count_eff < PACK_C);
   assign word_done = (count_eff == PACK_C) && out_free;
   assign flush     = FLUSH_EN && (state_reg == FILL) && !in_flight_reg
                      && (timer_reg == TMAX) && out_free;

   generate
      for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
         assign acc_land[gi]     = (in_flight_reg && (count_reg == CW'(gi))) ? fifo_rdata : acc_reg[gi];
         assign keep_partial[gi] = (CW'(gi) < count_reg);
         assign acc_masked[gi]   = keep_partial[gi] ? acc_reg[gi] : '0;
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      count_next     = count_eff[CW-1:0];
      in_flight_next = pop;
      timer_next     = '0;
      acc_next       = acc_land;
      m_valid_next   = m_valid_reg && !m_ready;
      m_data_next    = m_data_reg;
      m_keep_next    = m_keep_reg;

      // timer saturates at TMAX so a flush blocked by backpressure is retried
      if ((state_reg == FILL) && !in_flight_reg && fifo_empty) begin
         timer_next = (timer_reg == TMAX) ? timer_reg : timer_reg + 1'b1;
      end

      if (word_done) begin
         m_data_next  = acc_land;
         m_keep_next  = '1;
         m_valid_next = 1'b1;
         count_next   = '0;
         acc_next     = '0;
      end else if (flush) begin
         m_data_next  = acc_masked;
         m_keep_next  = keep_partial;
         m_valid_next = 1'b1;
         count_next   = '0;
         acc_next     = '0;
         timer_next   = '0;
      end

      case (state_reg)
         IDLE: begin
            if (in_flight_reg) state_next = FILL;
         end
         FILL: begin
            if (word_done || flush)        state_next = IDLE;
            else if (count_eff == PACK_C)  state_next = HOLD;
         end
         HOLD: begin
            if (word_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         in_flight_reg <= 1'b0;
         timer_reg     <= '0;
         acc_reg       <= '0;
         m_valid_reg   <= 1'b0;
         m_data_reg    <= '0;
         m_keep_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         in_flight_reg <= in_flight_next;
         timer_reg     <= timer_next;
         acc_reg       <= acc_next;
         m_valid_reg   <= m_valid_next;
         m_data_reg    <= m_data_next;
         m_keep_reg    <= m_keep_next;
      end
   end

   assign fifo_rd_en = pop;
   assign m_valid    = m_valid_reg;
   assign m_data     = m_data_reg;
   assign m_keep     = m_keep_reg;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a byte-grouping model queues expected words,
// a monitor pops and compares them as the DUT hands words off.
module tb_fifo_word_packer;

   localparam int DW = 8;
   localparam int PK = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rdata = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [31:0]   m_data;
   logic [3:0]    m_keep;

   logic          fifo_empty0 = 1'b1;
   logic          fifo_rd_en0;
   logic [DW-1:0] fifo_rdata0 = '0;
   logic          m_valid0;
   logic [31:0]   m_data0;
   logic [3:0]    m_keep0;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int pops        = 0;
   int pops0       = 0;
   int target0     = 0;
   bit seen_valid0 = 1'b0;

   logic [7:0]  fifo_q[$];
   logic [7:0]  model_bytes[$];
   logic [35:0] exp_q[$];
   int          accept_cyc[$];

   always #5 clk = ~clk;

   fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(TO)) dut (
      .rd_clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_keep(m_keep)
   );

   fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(0)) dut_noflush (
      .rd_clk(clk), .rst(rst), .fifo_empty(fifo_empty0), .fifo_rd_en(fifo_rd_en0),
      .fifo_rdata(fifo_rdata0), .m_valid(m_valid0), .m_ready(1'b1),
      .m_data(m_data0), .m_keep(m_keep0)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word();
      logic [31:0] w;
      logic [3:0]  k;
      w = '0;
      k = '0;
      for (int i = 0; i < model_bytes.size(); i++) begin
         w[8*i +: 8] = model_bytes[i];
         k[i]        = 1'b1;
      end
      exp_q.push_back({k, w});
      model_bytes.delete();
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      model_bytes.push_back(b);
      if (model_bytes.size() == PK) push_word();
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) tick();
   endtask

   // FIFO read ports: data appears the cycle after a pop, empty reflects post-pop occupancy
   task automatic fifo_model();
      int left0;
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
         if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_rdata <= fifo_q.pop_front();
            pops       <= pops + 1;
         end
         fifo_empty <= (fifo_q.size() == 0);
         left0 = target0 - pops0;
         if (fifo_rd_en0 && left0 > 0) begin
            fifo_rdata0 <= fifo_rdata0 + 8'd1;
            pops0       <= pops0 + 1;
            left0       = left0 - 1;
         end
         fifo_empty0 <= (left0 <= 0);
      end
   endtask

   task automatic monitor();
      logic [35:0] exp;
      logic [35:0] prev_word;
      logic        prev_stall;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (m_valid0) seen_valid0 = 1'b1;
            if (fifo_rd_en && fifo_empty) check("rd_on_empty", 64'(fifo_rd_en), 64'd0);
            if (prev_stall) check("hold", 64'({m_valid, m_keep, m_data}), 64'({1'b1, prev_word}));
            if (m_valid && m_ready) begin
               $display("word cyc=%0d data=0x%08h keep=0x%h", cyc, m_data, m_keep);
               if (exp_q.size() == 0) begin
                  check("unexp_word", 64'(exp_q.size()), 64'd1);
               end else begin
                  exp = exp_q.pop_front();
                  check("word", 64'({m_keep, m_data}), 64'(exp));
                  accept_cyc.push_back(cyc);
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_keep, m_data};
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int n;
      int lat;
      int words_before;

      fork
         fifo_model();
         monitor();
      join_none

      // reset with a non-empty FIFO
      rst = 1'b1;
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_data",  64'(m_data), 64'd0);
      check("rst_keep",  64'(m_keep), 64'd0);

      // streaming with m_ready held high
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ready = 1'b1;
      wait_drain(100);
      if (accept_cyc.size() >= 2) check("stream_gap", 64'(accept_cyc[1] - accept_cyc[0]), 64'd5);
      else check("stream_words", 64'(accept_cyc.size()), 64'd2);

      // backpressure: one word parked in the output, one in the accumulator
      m_ready = 1'b0;
      for (int i = 8'h21; i <= 8'h28; i++) push_byte(8'(i));
      repeat (20) tick();
      check("bp_consumed", 64'(fifo_q.size()), 64'd0);
      check("bp_word1", 64'({m_valid, m_data}), 64'({1'b1, 32'h24232221}));
      push_byte(8'h29);
      repeat (5) tick();
      check("bp_rd_en", 64'(fifo_rd_en), 64'd0);
      check("bp_pending", 64'(fifo_q.size()), 64'd1);
      push_byte(8'h2A);
      push_byte(8'h2B);
      push_byte(8'h2C);
      m_ready = 1'b1;
      wait_drain(100);

      // timeout flush of a 3-byte partial word
      p = pops;
      push_byte(8'hAA);
      push_byte(8'hBB);
      push_byte(8'hCC);
      push_word();
      n = 0;
      while (pops < p + 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("to_pops", 64'(pops - p), 64'd3);
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!m_valid && lat < 100);
      check("flush_lat", 64'(lat), 64'(TO + 1));
      #1;
      wait_drain(50);

      // flushing disabled instance: 3 bytes then a long idle
      target0 = 3;
      repeat (110) tick();
      check("noflush_valid", 64'(seen_valid0), 64'd0);
      check("noflush_pops", 64'(pops0), 64'd3);

      // reset mid-word discards the partial accumulator
      p = pops;
      push_byte(8'h51);
      push_byte(8'h52);
      n = 0;
      while (pops < p + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_bytes.delete();
      check("rst_mid_valid", 64'(m_valid), 64'd0);
      words_before = accept_cyc.size();
      for (int i = 8'h11; i <= 8'h14; i++) push_byte(8'(i));
      wait_drain(100);
      repeat (25) tick();
      check("rst_mid_words", 64'(accept_cyc.size() - words_before), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
